// File: rtl/state_to_vector_packer.sv
// -----------------------------------------------------------------------------
// state_to_vector_packer
//
// Purpose:
//   Assembles a 4x4 byte state, delivered one column per cycle, into a single
//   128-bit block. Row r of column c lands at o_vector[127-8*(4c+r) -: 8], so
//   column 0 is the most significant 32 bits and row 0 is the most significant
//   byte of each column.
//
//   Columns 0-2 are buffered in a 96-bit assembly register. The column-3
//   transfer loads the whole block into the output register in one step.
//   Because the assembly register is separate from the output register,
//   columns 0-2 of the next block can be accepted while a finished block
//   waits for the consumer. Only column 3 has to wait for the output slot.
//
// Ports:
//   i_clk       sole clock, rising edge
//   i_rst       synchronous active-high reset, highest priority
//   i_clear     discard the partially assembled block (output side untouched)
//   i_colValid  column bytes on i_row0..i_row3 are valid
//   o_colReady  packer accepts a column this cycle (combinational)
//   i_row0..3   bytes of the current column, row 0 to row 3
//   o_vector    packed 128-bit block (registered)
//   o_vecValid  o_vector holds a complete block (registered)
//   i_vecReady  downstream consumes o_vector this cycle
//   o_partial   at least one column of the next block is buffered (registered)
// -----------------------------------------------------------------------------
module state_to_vector_packer (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clear,
    input  logic         i_colValid,
    output logic         o_colReady,
    input  logic [7:0]   i_row0,
    input  logic [7:0]   i_row1,
    input  logic [7:0]   i_row2,
    input  logic [7:0]   i_row3,
    output logic [127:0] o_vector,
    output logic         o_vecValid,
    input  logic         i_vecReady,
    output logic         o_partial
);

    // Each state equals the index of the next column expected (colCnt).
    typedef enum logic [1:0] {
        FILL0 = 2'd0,
        FILL1 = 2'd1,
        FILL2 = 2'd2,
        FILL3 = 2'd3
    } fill_state_t;

    fill_state_t  r_state;
    fill_state_t  w_next_state;

    logic [95:0]  r_assembly;
    logic [95:0]  w_assembly_next;
    logic [127:0] r_vector;
    logic [127:0] w_vector_next;
    logic         r_vec_valid;
    logic         w_vec_valid_next;
    logic         r_partial;

    logic [31:0]  w_column;
    logic         w_col_ready;
    logic         w_col_xfer;
    logic         w_out_xfer;
    logic         w_block_done;

    // Row 0 is the most significant byte of the column word.
    assign w_column = {i_row0, i_row1, i_row2, i_row3};

    // Column acceptance.
    // Columns 0-2 only touch the assembly register, so they are always
    // accepted. Column 3 needs the output register. That register is free
    // when it holds no block, or when its block leaves on this same edge.
    always_comb begin
        w_col_ready = 1'b0;
        if (i_rst || i_clear) begin
            w_col_ready = 1'b0;
        end else if (r_state != FILL3) begin
            w_col_ready = 1'b1;
        end else begin
            w_col_ready = (!r_vec_valid) || i_vecReady;
        end
    end

    // Handshake qualifiers.
    assign w_col_xfer   = i_colValid && w_col_ready;
    assign w_out_xfer   = r_vec_valid && i_vecReady;
    assign w_block_done = w_col_xfer && (r_state == FILL3);

    // Fill-state sequencing. A clear wins over a column transfer; in any
    // case no column is accepted while clear is high.
    always_comb begin
        w_next_state = r_state;
        if (i_clear) begin
            w_next_state = FILL0;
        end else if (w_col_xfer) begin
            case (r_state)
                FILL0:   w_next_state = FILL1;
                FILL1:   w_next_state = FILL2;
                FILL2:   w_next_state = FILL3;
                FILL3:   w_next_state = FILL0;
                default: w_next_state = FILL0;
            endcase
        end else begin
            w_next_state = r_state;
        end
    end

    // Assembly register update for columns 0-2. The column-3 word bypasses
    // this register and goes straight into the output block.
    always_comb begin
        w_assembly_next = r_assembly;
        if (w_col_xfer) begin
            case (r_state)
                FILL0:   w_assembly_next[95:64] = w_column;
                FILL1:   w_assembly_next[63:32] = w_column;
                FILL2:   w_assembly_next[31:0]  = w_column;
                FILL3:   w_assembly_next        = r_assembly;
                default: w_assembly_next        = r_assembly;
            endcase
        end else begin
            w_assembly_next = r_assembly;
        end
    end

    // Output block register and valid flag. If a block completes on the
    // same edge that the old block is consumed, the new block replaces it
    // and valid stays high. Otherwise the block is held until it is consumed.
    always_comb begin
        w_vector_next    = r_vector;
        w_vec_valid_next = r_vec_valid;
        if (w_block_done) begin
            w_vector_next    = {r_assembly, w_column};
            w_vec_valid_next = 1'b1;
        end else if (w_out_xfer) begin
            w_vector_next    = r_vector;
            w_vec_valid_next = 1'b0;
        end else begin
            w_vector_next    = r_vector;
            w_vec_valid_next = r_vec_valid;
        end
    end

    // State registers with synchronous reset. Reset discards both the partial
    // block and any held output block.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= FILL0;
            r_assembly  <= 96'h0;
            r_vector    <= 128'h0;
            r_vec_valid <= 1'b0;
            r_partial   <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_assembly  <= w_assembly_next;
            r_vector    <= w_vector_next;
            r_vec_valid <= w_vec_valid_next;
            r_partial   <= (w_next_state != FILL0);
        end
    end

    assign o_colReady = w_col_ready;
    assign o_vector   = r_vector;
    assign o_vecValid = r_vec_valid;
    assign o_partial  = r_partial;

endmodule

// File: tb/tb_state_to_vector_packer.sv
// -----------------------------------------------------------------------------
// tb_state_to_vector_packer
//
// Directed table of per-cycle vectors with hand-computed expectations, then a
// randomized valid/ready sequence checked against a reference packing model
// and a scoreboard of expected blocks.
// -----------------------------------------------------------------------------
module tb_state_to_vector_packer;

    logic         i_clk;
    logic         i_rst;
    logic         i_clear;
    logic         i_colValid;
    logic         o_colReady;
    logic [7:0]   i_row0;
    logic [7:0]   i_row1;
    logic [7:0]   i_row2;
    logic [7:0]   i_row3;
    logic [127:0] o_vector;
    logic         o_vecValid;
    logic         i_vecReady;
    logic         o_partial;

    int errors;
    int checks;

    typedef struct {
        logic         rst;
        logic         clr;
        logic         cv;
        logic [31:0]  col;
        logic         vr;
        logic         erdy;
        logic         evv;
        logic [127:0] evec;
        logic         epart;
    } vec_t;

    vec_t vecs[$];

    state_to_vector_packer dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clear    (i_clear),
        .i_colValid (i_colValid),
        .o_colReady (o_colReady),
        .i_row0     (i_row0),
        .i_row1     (i_row1),
        .i_row2     (i_row2),
        .i_row3     (i_row3),
        .o_vector   (o_vector),
        .o_vecValid (o_vecValid),
        .i_vecReady (i_vecReady),
        .o_partial  (o_partial)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] colw(input logic [127:0] blk, input int c);
        return blk[127-32*c -: 32];
    endfunction

    task automatic drive(input logic rst, input logic clr, input logic cv,
                         input logic [31:0] col, input logic vr);
        i_rst      = rst;
        i_clear    = clr;
        i_colValid = cv;
        i_row0     = col[31:24];
        i_row1     = col[23:16];
        i_row2     = col[15:8];
        i_row3     = col[7:0];
        i_vecReady = vr;
    endtask

    task automatic add(input logic rst, input logic clr, input logic cv,
                       input logic [31:0] col, input logic vr, input logic erdy,
                       input logic evv, input logic [127:0] evec, input logic epart);
        vec_t v;
        v.rst = rst; v.clr = clr; v.cv = cv; v.col = col; v.vr = vr;
        v.erdy = erdy; v.evv = evv; v.evec = evec; v.epart = epart;
        vecs.push_back(v);
    endtask

    // Adds the four columns of blk back to back, all with the same ready.
    // Expectations: columns 0-2 leave o_vecValid/o_vector at pvv/pvec with
    // o_partial=1, column 3 produces blk with valid and partial clear.
    task automatic add_block(input logic [127:0] blk, input logic vr,
                             input logic pvv, input logic [127:0] pvec);
        for (int c = 0; c < 3; c++) begin
            add(1'b0, 1'b0, 1'b1, colw(blk, c), vr, 1'b1, pvv, pvec, 1'b1);
        end
        add(1'b0, 1'b0, 1'b1, colw(blk, 3), vr, 1'b1, 1'b1, blk, 1'b0);
    endtask

    // Reference model state for the random phase
    int           m_cnt;
    logic [95:0]  m_asm;
    logic         m_vv;
    logic [127:0] m_vec;
    logic [127:0] sb[$];

    localparam logic [127:0] BA = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] BB = 128'h01020304_05060708_090a0b0c_0d0e0f10;
    localparam logic [127:0] BC = 128'h11121314_15161718_191a1b1c_1d1e1f20;
    localparam logic [127:0] BD = 128'ha0a1a2a3_a4a5a6a7_a8a9aaab_acadaeaf;
    localparam logic [127:0] BE = 128'he0e1e2e3_e4e5e6e7_e8e9eaeb_ecedeeef;
    localparam logic [127:0] BF = 128'hf0f1f2f3_f4f5f6f7_f8f9fafb_fcfdfeff;
    localparam logic [127:0] BG = 128'h5a5b5c5d_6a6b6c6d_7a7b7c7d_8a8b8c8d;
    localparam logic [127:0] Z  = 128'h0;

    initial begin
        errors = 0;
        checks = 0;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

        // Reset state
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        chk("rst_vv",   {127'h0, o_vecValid}, Z);
        chk("rst_vec",  o_vector, Z);
        chk("rst_part", {127'h0, o_partial}, Z);
        chk("rst_rdy",  {127'h0, o_colReady}, Z);

        // Basic block, consumed the cycle after it appears (valid for exactly one cycle)
        add_block(BA, 1'b1, 1'b0, Z);
        add(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, BA, 1'b0);

        // Block B held, block C columns 0-2 accepted while held
        add_block(BB, 1'b0, 1'b0, BA);
        for (int c = 0; c < 3; c++) begin
            add(1'b0, 1'b0, 1'b1, colw(BC, c), 1'b0, 1'b1, 1'b1, BB, 1'b1);
        end
        // Column 3 stalls until ready
        add(1'b0, 1'b0, 1'b1, colw(BC, 3), 1'b0, 1'b0, 1'b1, BB, 1'b1);
        add(1'b0, 1'b0, 1'b1, colw(BC, 3), 1'b0, 1'b0, 1'b1, BB, 1'b1);
        // Column 3 on the same edge as the output transfer
        add(1'b0, 1'b0, 1'b1, colw(BC, 3), 1'b1, 1'b1, 1'b1, BC, 1'b0);
        add(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, BC, 1'b0);
        add(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, BC, 1'b0);

        // Two columns, clear drops a column, then a full block
        add(1'b0, 1'b0, 1'b1, colw(BD, 0), 1'b1, 1'b1, 1'b0, BC, 1'b1);
        add(1'b0, 1'b0, 1'b1, colw(BD, 1), 1'b1, 1'b1, 1'b0, BC, 1'b1);
        add(1'b0, 1'b1, 1'b1, 32'hdeadbeef, 1'b1, 1'b0, 1'b0, BC, 1'b0);
        add_block(BD, 1'b1, 1'b0, BC);
        add(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, BD, 1'b0);
        // Clear does not block the output transfer
        add(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, BD, 1'b0);

        // Block held plus three columns, then reset
        add_block(BE, 1'b0, 1'b0, BD);
        for (int c = 0; c < 3; c++) begin
            add(1'b0, 1'b0, 1'b1, colw(BF, c), 1'b0, 1'b1, 1'b1, BE, 1'b1);
        end
        add(1'b1, 1'b0, 1'b1, colw(BF, 3), 1'b1, 1'b0, 1'b0, Z, 1'b0);
        add(1'b1, 1'b1, 1'b1, colw(BF, 3), 1'b1, 1'b0, 1'b0, Z, 1'b0);
        add_block(BG, 1'b1, 1'b0, Z);
        add(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, BG, 1'b0);

        // Apply the table
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge i_clk);
            drive(vecs[i].rst, vecs[i].clr, vecs[i].cv, vecs[i].col, vecs[i].vr);
            #1;
            chk($sformatf("v%0d_rdy", i), {127'h0, o_colReady}, {127'h0, vecs[i].erdy});
            @(posedge i_clk);
            #1;
            chk($sformatf("v%0d_vv", i),   {127'h0, o_vecValid}, {127'h0, vecs[i].evv});
            chk($sformatf("v%0d_vec", i),  o_vector, vecs[i].evec);
            chk($sformatf("v%0d_part", i), {127'h0, o_partial}, {127'h0, vecs[i].epart});
        end

        // Random stalls against a reference model. The model starts empty
        // after a reset.
        @(negedge i_clk);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge i_clk);
        m_cnt = 0;
        m_asm = 96'h0;
        m_vv  = 1'b0;
        m_vec = 128'h0;
        for (int n = 0; n < 600; n++) begin
            logic        clr;
            logic        cv;
            logic        vr;
            logic [31:0] col;
            logic        rdy;
            logic        cx;
            logic        ox;
            clr = ($urandom_range(0, 15) == 0);
            cv  = ($urandom_range(0, 3) != 0);
            vr  = ($urandom_range(0, 2) != 0);
            col = $urandom;
            drive(1'b0, clr, cv, col, vr);
            rdy = !clr && ((m_cnt != 3) || !m_vv || vr);
            cx  = cv && rdy;
            ox  = m_vv && vr;
            #1;
            chk($sformatf("r%0d_rdy", n), {127'h0, o_colReady}, {127'h0, rdy});
            if (ox) begin
                if (sb.size() == 0) begin
                    chk($sformatf("r%0d_sb_empty", n), 128'h1, 128'h0);
                end else begin
                    chk($sformatf("r%0d_out", n), o_vector, sb.pop_front());
                end
            end
            // Model update
            if (clr) begin
                m_cnt = 0;
                if (ox) m_vv = 1'b0;
            end else if (cx && m_cnt == 3) begin
                m_vec = {m_asm, col};
                m_vv  = 1'b1;
                sb.push_back({m_asm, col});
                m_cnt = 0;
            end else begin
                if (cx) begin
                    m_asm[95-32*m_cnt -: 32] = col;
                    m_cnt = m_cnt + 1;
                end
                if (ox) m_vv = 1'b0;
            end
            @(posedge i_clk);
            #1;
            chk($sformatf("r%0d_vv", n),   {127'h0, o_vecValid}, {127'h0, m_vv});
            chk($sformatf("r%0d_vec", n),  o_vector, m_vec);
            chk($sformatf("r%0d_part", n), {127'h0, o_partial}, {127'h0, (m_cnt != 0)});
            @(negedge i_clk);
        end
        // No block lost or duplicated: only the still-held block may remain.
        chk("sb_left", sb.size(), {127'h0, m_vv});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
